// File: rtl/f1_sequencer.sv
// F1 start-light sequencer: fills eight lights, holds for a random delay,
// then times the driver's reaction in ticks and flags jump starts.
module f1_sequencer #(
  parameter int STEP_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        react,
  input  logic [13:0] lfsr_val,
  input  logic        time_out,
  output logic [7:0]  lights,
  output logic        en_lfsr,
  output logic [13:0] delay_n,
  output logic        delay_trigger,
  output logic [13:0] reaction_ms,
  output logic        jump_start,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HOLD,
    S_TIMING,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [9:0] STEP_LAST = 10'(STEP_TICKS - 1);

  state_e      state_q, state_d;
  logic [9:0]  step_q, step_d;
  logic [7:0]  lights_q, lights_d;
  logic [13:0] delay_n_q, delay_n_d;
  logic [13:0] cnt_q, cnt_d;
  logic [13:0] react_q, react_d;
  logic        jump_q, jump_d;

  logic [7:0]  lights_nxt;
  logic [13:0] cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      lights_q  <= '0;
      delay_n_q <= '0;
      cnt_q     <= '0;
      react_q   <= '0;
      jump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      lights_q  <= lights_d;
      delay_n_q <= delay_n_d;
      cnt_q     <= cnt_d;
      react_q   <= react_d;
      jump_q    <= jump_d;
    end
  end

  assign lights_nxt = {lights_q[6:0], 1'b1};
  assign cnt_inc    = (cnt_q == 14'h3FFF) ? cnt_q : cnt_q + 14'd1;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    lights_d  = lights_q;
    delay_n_d = delay_n_q;
    cnt_d     = cnt_q;
    react_d   = react_q;
    jump_d    = jump_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        lights_d = '0;
        if (start) begin
          state_d = S_FILL;
          step_d  = '0;
          jump_d  = 1'b0;
        end
      end
      S_FILL: begin
        // react wins over a light step landing on the same clk
        if (react) begin
          state_d  = S_FAULT;
          jump_d   = 1'b1;
          lights_d = '0;
        end else if (tick) begin
          if (step_q == STEP_LAST) begin
            step_d   = '0;
            lights_d = lights_nxt;
            if (lights_nxt == 8'hFF) begin
              state_d   = S_HOLD;
              delay_n_d = (lfsr_val == '0) ? 14'd1 : lfsr_val;
            end
          end else begin
            step_d = step_q + 10'd1;
          end
        end
      end
      S_HOLD: begin
        if (react) begin
          state_d  = S_FAULT;
          jump_d   = 1'b1;
          lights_d = '0;
        end else if (time_out) begin
          state_d  = S_TIMING;
          lights_d = '0;
          cnt_d    = '0;
        end
      end
      S_TIMING: begin
        if (tick) cnt_d = cnt_inc;
        if (react) begin
          state_d = S_DONE;
          react_d = tick ? cnt_inc : cnt_q;
        end
      end
      default: begin
        state_d  = S_IDLE;
        lights_d = '0;
      end
    endcase
  end

  always_comb begin
    lights        = lights_q;
    delay_n       = delay_n_q;
    reaction_ms   = react_q;
    jump_start    = jump_q;
    en_lfsr       = (state_q != S_HOLD);
    delay_trigger = (state_q == S_HOLD);
    busy          = (state_q == S_FILL) || (state_q == S_HOLD) ||
                    (state_q == S_TIMING);
  end

endmodule

// File: tb/tb_f1_sequencer.sv
// Scoreboard bench for f1_sequencer with STEP_TICKS=2.
// Expected lights and reaction values are queued as stimulus is driven.
module tb_f1_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic [13:0] lfsr_val = 14'h1234;
  logic        time_out = 1'b0;
  logic [7:0]  lights;
  logic        en_lfsr;
  logic [13:0] delay_n;
  logic        delay_trigger;
  logic [13:0] reaction_ms;
  logic        jump_start;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  lq[$];
  logic [13:0] rq[$];

  f1_sequencer #(.STEP_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .react(react),
    .lfsr_val(lfsr_val), .time_out(time_out), .lights(lights),
    .en_lfsr(en_lfsr), .delay_n(delay_n), .delay_trigger(delay_trigger),
    .reaction_ms(reaction_ms), .jump_start(jump_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input int gap = 3);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_react();
    react = 1'b1; cyc(); react = 1'b0;
  endtask

  task automatic pulse_to();
    time_out = 1'b1; cyc(); time_out = 1'b0;
  endtask

  task automatic run_to_hold();
    pulse_start();
    repeat (16) do_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_checks++;
    if ({lights, en_lfsr, delay_n, delay_trigger, reaction_ms, jump_start, busy}
        !== {8'h00, 1'b1, 14'd0, 1'b0, 14'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: lights=%h en=%b dn=%0d trig=%b rm=%0d js=%b busy=%b",
               lights, en_lfsr, delay_n, delay_trigger, reaction_ms, jump_start, busy);
    end
    rst = 1'b0;
    cyc();
    pulse_to();
    pulse_react();
    n_checks++;
    if (busy !== 1'b0 || en_lfsr !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%b en=%b want 0 1", busy, en_lfsr);
    end
  endtask

  task automatic test_fill();
    logic [7:0] prev;
    logic [7:0] e;
    lfsr_val = 14'h1234;
    e = 8'h00;
    for (int i = 0; i < 8; i++) begin
      e = {e[6:0], 1'b1};
      lq.push_back(e);
    end
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || lights !== 8'h00) begin
      n_fail++;
      $display("FAIL fill_entry: busy=%b lights=%h want 1 00", busy, lights);
    end
    prev = lights;
    for (int t = 0; t < 16; t++) begin
      if (t == 3) pulse_start();
      do_tick();
      if (lights !== prev) begin
        n_checks++;
        if (lq.size() == 0) begin
          n_fail++;
          $display("FAIL light_step: unexpected lights=%h", lights);
        end else begin
          e = lq.pop_front();
          if (lights !== e) begin
            n_fail++;
            $display("FAIL light_step: got %h want %h", lights, e);
          end
        end
        prev = lights;
      end
    end
    n_checks++;
    if (lq.size() != 0) begin
      n_fail++;
      $display("FAIL light_count: %0d steps missing", lq.size());
      lq.delete();
    end
    n_checks++;
    if ({delay_trigger, en_lfsr, busy, lights, delay_n}
        !== {1'b1, 1'b0, 1'b1, 8'hFF, 14'h1234}) begin
      n_fail++;
      $display("FAIL hold_entry: trig=%b en=%b busy=%b lights=%h dn=%h want 1 0 1 ff 1234",
               delay_trigger, en_lfsr, busy, lights, delay_n);
    end
    lfsr_val = 14'h0777;
    cyc(5);
    n_checks++;
    if (delay_n !== 14'h1234 || lights !== 8'hFF) begin
      n_fail++;
      $display("FAIL hold_stable: dn=%h lights=%h want 1234 ff", delay_n, lights);
    end
  endtask

  task automatic test_zero_delay();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    lfsr_val = 14'd5;
    pulse_start();
    repeat (15) do_tick();
    lfsr_val = 14'd0;
    do_tick();
    n_checks++;
    if (delay_n !== 14'd1 || delay_trigger !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_delay: dn=%0d trig=%b want 1 1", delay_n, delay_trigger);
    end
    lfsr_val = 14'h0ABC;
    pulse_to();
    n_checks++;
    if ({lights, busy, en_lfsr, delay_trigger} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timing_entry: lights=%h busy=%b en=%b trig=%b want 00 1 1 0",
               lights, busy, en_lfsr, delay_trigger);
    end
    pulse_to();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || lights !== 8'h00) begin
      n_fail++;
      $display("FAIL timing_ignore: busy=%b lights=%h want 1 00", busy, lights);
    end
  endtask

  task automatic test_timing();
    logic [13:0] e;
    repeat (37) do_tick();
    rq.push_back(14'd37);
    pulse_react();
    n_checks++;
    e = rq.pop_front();
    if (busy !== 1'b0 || reaction_ms !== e || jump_start !== 1'b0) begin
      n_fail++;
      $display("FAIL react_37: busy=%b rm=%0d js=%b want 0 %0d 0",
               busy, reaction_ms, jump_start, e);
    end
    pulse_react();
    pulse_to();
    n_checks++;
    if (reaction_ms !== e || busy !== 1'b0 || lights !== 8'h00) begin
      n_fail++;
      $display("FAIL done_hold: rm=%0d busy=%b lights=%h want %0d 0 00",
               reaction_ms, busy, lights, e);
    end
    run_to_hold();
    pulse_to();
    repeat (36) do_tick();
    rq.push_back(14'd37);
    tick = 1'b1; react = 1'b1;
    cyc();
    tick = 1'b0; react = 1'b0;
    n_checks++;
    e = rq.pop_front();
    if (reaction_ms !== e || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL react_on_tick: rm=%0d busy=%b want %0d 0", reaction_ms, busy, e);
    end
  endtask

  task automatic test_jump_start();
    pulse_start();
    n_checks++;
    if (jump_start !== 1'b0 || busy !== 1'b1 || lights !== 8'h00) begin
      n_fail++;
      $display("FAIL done_restart: js=%b busy=%b lights=%h want 0 1 00",
               jump_start, busy, lights);
    end
    repeat (6) do_tick();
    n_checks++;
    if (lights !== 8'h07) begin
      n_fail++;
      $display("FAIL third_light: got %h want 07", lights);
    end
    pulse_react();
    n_checks++;
    if ({jump_start, lights, busy, en_lfsr} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_fault: js=%b lights=%h busy=%b en=%b want 1 00 0 1",
               jump_start, lights, busy, en_lfsr);
    end
    pulse_start();
    n_checks++;
    if (jump_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_restart: js=%b busy=%b want 0 1", jump_start, busy);
    end
    repeat (16) do_tick();
    react = 1'b1; time_out = 1'b1;
    cyc();
    react = 1'b0; time_out = 1'b0;
    n_checks++;
    if ({jump_start, lights, busy, delay_trigger} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_fault: js=%b lights=%h busy=%b trig=%b want 1 00 0 0",
               jump_start, lights, busy, delay_trigger);
    end
  endtask

  task automatic test_saturate();
    logic [13:0] e;
    run_to_hold();
    pulse_to();
    repeat (20000) do_tick(1);
    rq.push_back(14'h3FFF);
    pulse_react();
    e = rq.pop_front();
    n_checks++;
    if (reaction_ms !== e || busy !== 1'b0 || jump_start !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate: rm=%0d busy=%b js=%b want %0d 0 0",
               reaction_ms, busy, jump_start, e);
    end
  endtask

  task automatic test_reset_hold();
    run_to_hold();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lights, en_lfsr, delay_n, delay_trigger, reaction_ms, jump_start, busy}
        !== {8'h00, 1'b1, 14'd0, 1'b0, 14'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: lights=%h en=%b dn=%0d trig=%b rm=%0d js=%b busy=%b",
               lights, en_lfsr, delay_n, delay_trigger, reaction_ms, jump_start, busy);
    end
    cyc();
    rst = 1'b0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || lights !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_start: busy=%b lights=%h want 1 00", busy, lights);
    end
    repeat (2) do_tick();
    n_checks++;
    if (lights !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset_step: got %h want 01", lights);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_zero_delay();
    test_timing();
    test_jump_start();
    test_saturate();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/f1_sequencer.md
F1_SEQUENCER -- requirements
Module: f1_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 500, meaning tick pulses between successive lights turning on (legal range 1..1023).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state on posedge.
- rst  in  1  reset, asynchronous and active-high.
- tick  in  1  1 ms strobe, one clk wide.
- start  in  1  start request, one clk wide.
- react  in  1  driver reaction button, synchronised and one clk wide.
- lfsr_val  in  14  current pseudo-random value.
- time_out  in  1  delay-complete pulse from the delay counter.
- lights  out  8  light outputs, bit 0 first on.
- en_lfsr  out  1  high lets the LFSR run and holds the delay counter in reset.
- delay_n  out  14  delay load value in clk cycles.
- delay_trigger  out  1  level enable for the delay counter.
- reaction_ms  out  14  measured reaction time in ticks.
- jump_start  out  1  jump-start flag.
- busy  out  1  high in FILL, HOLD and TIMING.

Function
REQ-003 SHALL implement states IDLE, FILL, HOLD, TIMING, DONE and FAULT, encoded as registered state.
REQ-004 IDLE SHALL set lights=0 and en_lfsr=1; a start pulse SHALL move to FILL on the next clk, clearing the step counter and lights.
REQ-005 In FILL, a 10-bit step counter SHALL increment on each tick; when it reaches STEP_TICKS-1 on a tick, it SHALL clear and lights SHALL update to {lights[6:0],1'b1} on that clk.
REQ-006 On the clk where lights becomes 8'hFF, the block SHALL enter HOLD, and delay_n SHALL capture lfsr_val (a value of 0 SHALL be replaced by 1).
REQ-007 In HOLD, delay_trigger SHALL be 1, en_lfsr SHALL be 0, lights SHALL remain 8'hFF, and delay_n SHALL remain stable.
REQ-008 A time_out pulse in HOLD SHALL move the block to TIMING on the next clk, with lights=0 and the reaction counter cleared to 0.
REQ-009 In TIMING, the reaction counter SHALL increment on each tick and saturate at 14'h3FFF.
REQ-010 A react pulse in TIMING SHALL move the block to DONE, and reaction_ms SHALL capture the counter value plus 1 if tick is high in the same clk (saturating).
REQ-011 A react pulse in FILL or HOLD SHALL move the block to FAULT with jump_start=1 and lights=0; react SHALL take priority over a simultaneous time_out or light step.
REQ-012 DONE and FAULT SHALL hold reaction_ms, jump_start and lights=0; a start pulse SHALL clear jump_start and enter FILL.
REQ-013 A start pulse in FILL, HOLD or TIMING SHALL be ignored.
REQ-014 A react pulse in IDLE, DONE or FAULT SHALL be ignored.
REQ-015 A time_out pulse outside HOLD SHALL be ignored.
REQ-016 en_lfsr SHALL be 1 in every state except HOLD; delay_trigger SHALL be 1 only in HOLD; busy SHALL be 1 in FILL, HOLD and TIMING.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-018 Asserting rst SHALL immediately force state=IDLE, lights=0, en_lfsr=1, delay_n=0, delay_trigger=0, reaction_ms=0, jump_start=0, busy=0, and step and reaction counters to 0.
REQ-019 Asserting rst mid-sequence in any state SHALL abort the run with no partial result retained; operation SHALL resume on the first clk edge after rst deasserts.

Verification (STEP_TICKS=2, tick every 4 clk)
REQ-020 start, then 16 ticks -> lights steps 01,03,07,...,FF one step every 2 ticks; HOLD entered with delay_n=lfsr_val.
REQ-021 lfsr_val=0 at the 8th step -> delay_n=1; time_out -> TIMING with lights=0.
REQ-022 time_out, then 37 ticks, then react -> DONE with reaction_ms=37 and jump_start=0; react on a tick clk after 36 ticks -> reaction_ms=37.
REQ-023 react after the 3rd light (lights=07) -> FAULT with jump_start=1 and lights=0; react coincident with time_out in HOLD -> FAULT.
REQ-024 20000 ticks in TIMING with no react -> counter saturates; a subsequent react -> reaction_ms=16383.
REQ-025 rst pulsed in HOLD -> all outputs at reset values in the same cycle; start during FILL -> no effect on lights progression; start in DONE -> new FILL with jump_start=0.
